// File: rtl/inst_cache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache: segment bases,
// FSM state encoding and the virtual-to-physical fetch address decode.
package inst_cache_dm_pkg;

    localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
    localparam logic [31:0] KSEG1_BASE = 32'ha000_0000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        MISS_REQ  = 3'd2,
        MISS_WAIT = 3'd3,
        RESP      = 3'd4
    } state_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        uncached;
    } addr_dec_t;

    // kseg0/kseg1 strip the top three bits; every other segment maps 1:1.
    function automatic addr_dec_t decode_addr(input logic [31:0] vaddr);
        addr_dec_t d;
        logic      seg_k0;
        logic      seg_k1;
        seg_k0 = (vaddr[31:29] == KSEG0_BASE[31:29]);
        seg_k1 = (vaddr[31:29] == KSEG1_BASE[31:29]);
        d.paddr = (seg_k0 || seg_k1) ? {3'b000, vaddr[28:0]} : vaddr;
        d.paddr[1:0] = 2'b00;
        d.uncached = seg_k1;
        return d;
    endfunction

endpackage

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage for the instruction cache: combinational read,
// synchronous write, valid bits cleared by reset (tags and data are not).
module inst_cache_array #(
    parameter int INDEX_BITS = 7,
    parameter int TAG_BITS   = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] i_rd_idx,
    output logic                  o_rd_valid,
    output logic [TAG_BITS-1:0]   o_rd_tag,
    output logic [31:0]           o_rd_data,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_idx,
    input  logic [TAG_BITS-1:0]   i_wr_tag,
    input  logic [31:0]           i_wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    r_valid;
    logic [TAG_BITS-1:0] r_tag  [LINES];
    logic [31:0]         r_data [LINES];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/inst_cache_dm.sv
// Direct-mapped, one-word-line instruction cache between the fetch stage and
// the SRAM-like instruction bus; kseg1 fetches bypass the arrays.
module inst_cache_dm
    import inst_cache_dm_pkg::*;
#(
    parameter int INDEX_BITS = 7,
    parameter int TAG_BITS   = 32 - INDEX_BITS - 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cache_call_begin,
    input  logic [31:0] fetch_addr,
    output logic        cache_return_ready,
    output logic [31:0] cache_return_instruction,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        cache_busy
);

    state_t        r_state;
    logic [31:0]   r_paddr;
    logic          r_uncached;
    logic          r_hit;

    addr_dec_t     w_dec;
    logic          w_rd_valid;
    logic [TAG_BITS-1:0] w_rd_tag;
    logic [31:0]   w_rd_data;
    logic          w_hit;
    logic          w_capture;
    logic          w_fill;

    assign w_dec = decode_addr(fetch_addr);

    // The lookup is resolved against the incoming address in IDLE so that the
    // registered ready pulse lands in the LOOKUP cycle.
    assign w_hit = !w_dec.uncached && w_rd_valid
                   && (w_rd_tag == w_dec.paddr[31:INDEX_BITS+2]);

    assign w_capture = ((r_state == MISS_REQ) && inst_addr_ok && inst_data_ok)
                    || ((r_state == MISS_WAIT) && inst_data_ok);
    assign w_fill    = w_capture && !r_uncached;

    inst_cache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .i_rd_idx   (w_dec.paddr[INDEX_BITS+1:2]),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_fill),
        .i_wr_idx   (r_paddr[INDEX_BITS+1:2]),
        .i_wr_tag   (r_paddr[31:INDEX_BITS+2]),
        .i_wr_data  (inst_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state                  <= IDLE;
            r_paddr                  <= '0;
            r_uncached               <= 1'b0;
            r_hit                    <= 1'b0;
            cache_return_ready       <= 1'b0;
            cache_return_instruction <= 32'h0;
            inst_req                 <= 1'b0;
            inst_addr                <= 32'h0;
            cache_busy               <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cache_call_begin) begin
                        r_paddr                  <= w_dec.paddr;
                        r_uncached               <= w_dec.uncached;
                        r_hit                    <= w_hit;
                        cache_return_ready       <= w_hit;
                        cache_return_instruction <= w_hit ? w_rd_data : 32'h0;
                        cache_busy               <= 1'b1;
                        r_state                  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    cache_return_ready       <= 1'b0;
                    cache_return_instruction <= 32'h0;
                    if (r_hit) begin
                        cache_busy <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        inst_req  <= 1'b1;
                        inst_addr <= r_paddr;
                        r_state   <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (inst_addr_ok) begin
                        inst_req <= 1'b0;
                        if (inst_data_ok) begin
                            cache_return_ready       <= 1'b1;
                            cache_return_instruction <= inst_rdata;
                            r_state                  <= RESP;
                        end else begin
                            r_state <= MISS_WAIT;
                        end
                    end
                end
                MISS_WAIT: begin
                    if (inst_data_ok) begin
                        cache_return_ready       <= 1'b1;
                        cache_return_instruction <= inst_rdata;
                        r_state                  <= RESP;
                    end
                end
                RESP: begin
                    cache_return_ready       <= 1'b0;
                    cache_return_instruction <= 32'h0;
                    cache_busy               <= 1'b0;
                    r_state                  <= IDLE;
                end
                default: begin
                    cache_return_ready       <= 1'b0;
                    cache_return_instruction <= 32'h0;
                    inst_req                 <= 1'b0;
                    cache_busy               <= 1'b0;
                    r_state                  <= IDLE;
                end
            endcase
        end
    end

endmodule
